// File: rtl/pe_array_pkg.sv
// Shared defaults for the PE systolic array: word width, column count, drain FIFO depth.
// Used by the array core, the feeder and the drain reader.
package pe_array_pkg;

  localparam int PE_DATA_WIDTH = 32;
  localparam int PE_COLS       = 4;
  localparam int PE_DEPTH      = 4;
  localparam int PE_CNT_WIDTH  = $clog2(PE_DEPTH) + 1;

  // Occupancy counters need one extra bit so that a full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pe_row_fifo.sv
// Synchronous FIFO of whole result rows with a registered head-row output.
// Valid/ready: a pop is taken only when the FIFO is non-empty; a push into a full FIFO succeeds only with a same-cycle pop.
module pe_row_fifo
  import pe_array_pkg::*;
#(
  parameter int WIDTH = PE_DATA_WIDTH * PE_COLS,
  parameter int DEPTH = PE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    rd_nxt   = rd_ptr + AW'(1);
    cnt_nxt  = cnt;
    if (push_ok && !pop_ok) cnt_nxt = cnt + CW'(1);
    else if (!push_ok && pop_ok) cnt_nxt = cnt - CW'(1);
    // The output register always tracks the entry that will be at the head next cycle.
    dout_nxt = dout;
    if (pop_ok) begin
      if (cnt > CW'(1)) dout_nxt = mem[rd_nxt];
      else if (push_ok) dout_nxt = din;
    end else if (empty && push_ok) begin
      dout_nxt = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      cnt  <= cnt_nxt;
      dout <= dout_nxt;
    end
  end

endmodule

// File: rtl/pe_col_drain.sv
// Bottom-edge drain of the PE array: deskews per-column results into aligned rows and queues them for the result path.
// Build option PE_COL_DRAIN_RELU_EN clamps negative words of each row to zero before they are queued.
module pe_col_drain
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int COLS       = PE_COLS,
  parameter int DEPTH      = PE_DEPTH
) (
  input  logic                       DRN_clk,
  input  logic                       DRN_rst,
  input  logic                       DRN_clr,
  input  logic [COLS-1:0]            DRN_en_up,
  input  logic [COLS*DATA_WIDTH-1:0] DRN_data_up,
  output logic                       DRN_valid,
  input  logic                       DRN_ready,
  output logic [COLS*DATA_WIDTH-1:0] DRN_data,
  output logic [$clog2(DEPTH):0]     DRN_count,
  output logic                       DRN_overflow,
  output logic                       DRN_skew_err
);

  logic [COLS-1:0]            al_en;
  logic [DATA_WIDTH-1:0]      al_data [COLS];
  logic [COLS*DATA_WIDTH-1:0] row;
  logic [COLS-2:0]            guard;
  logic                       row_live;
  logic                       row_push;
  logic                       row_partial;
  logic                       fifo_full;
  logic                       fifo_empty;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int STAGES = COLS - 1 - j;
    if (STAGES == 0) begin : g_pass
      assign al_en[j]   = DRN_en_up[j];
      assign al_data[j] = DRN_data_up[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [STAGES-1:0]     en_q;
      logic [DATA_WIDTH-1:0] d_q [STAGES];

      always_ff @(posedge DRN_clk or posedge DRN_rst) begin
        if (DRN_rst || DRN_clr) begin
          en_q <= '0;
          for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
        end else begin
          en_q[0] <= DRN_en_up[j];
          if (DRN_en_up[j]) d_q[0] <= DRN_data_up[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < STAGES; k++) begin
            en_q[k] <= en_q[k-1];
            if (en_q[k-1]) d_q[k] <= d_q[k-1];
          end
        end
      end

      assign al_en[j]   = en_q[STAGES-1];
      assign al_data[j] = d_q[STAGES-1];
    end
  end

  // For COLS-1 cycles after reset or flush, aligned slots can only hold remnants of rows
  // started before the flush; they are dropped silently rather than reported as skew.
  always_ff @(posedge DRN_clk or posedge DRN_rst) begin
    if (DRN_rst)      guard <= '1;
    else if (DRN_clr) guard <= '1;
    else              guard <= guard >> 1;
  end

  assign row_live    = ~(|guard);
  assign row_push    = row_live & (&al_en) & ~DRN_clr;
  assign row_partial = row_live & (|al_en) & ~(&al_en);

  always_comb begin
    row = '0;
    for (int j = 0; j < COLS; j++) begin
`ifdef PE_COL_DRAIN_RELU_EN
      row[j*DATA_WIDTH +: DATA_WIDTH] = al_data[j][DATA_WIDTH-1] ? '0 : al_data[j];
`else
      row[j*DATA_WIDTH +: DATA_WIDTH] = al_data[j];
`endif
    end
  end

  always_ff @(posedge DRN_clk or posedge DRN_rst) begin
    if (DRN_rst || DRN_clr) begin
      DRN_overflow <= 1'b0;
      DRN_skew_err <= 1'b0;
    end else begin
      if (row_partial) DRN_skew_err <= 1'b1;
      if (row_push && fifo_full && !(DRN_ready && !fifo_empty)) DRN_overflow <= 1'b1;
    end
  end

  pe_row_fifo #(
    .WIDTH (COLS*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (DRN_clk),
    .rst   (DRN_rst),
    .clr   (DRN_clr),
    .push  (row_push),
    .pop   (DRN_ready),
    .din   (row),
    .dout  (DRN_data),
    .count (DRN_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign DRN_valid = ~fifo_empty;

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: scheduled skewed rows, a queue-level reference model and a per-cycle monitor.
module tb_pe_col_drain;
  import pe_array_pkg::*;

  localparam int W       = 32;
  localparam int C       = 4;
  localparam int D       = 4;
  localparam int CW      = $clog2(D) + 1;
  localparam int MAXC    = 1400;
  localparam int END_CYC = 1320;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clr = 1'b0;
  logic           ready = 1'b0;
  logic [C-1:0]   en_up = '0;
  logic [C*W-1:0] data_up = '0;
  logic           valid;
  logic [C*W-1:0] data;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           skew_err;

  pe_col_drain #(.DATA_WIDTH(W), .COLS(C), .DEPTH(D)) dut (
    .DRN_clk      (clk),
    .DRN_rst      (rst),
    .DRN_clr      (clr),
    .DRN_en_up    (en_up),
    .DRN_data_up  (data_up),
    .DRN_valid    (valid),
    .DRN_ready    (ready),
    .DRN_data     (data),
    .DRN_count    (count),
    .DRN_overflow (overflow),
    .DRN_skew_err (skew_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus schedule, indexed by cycle number.
  logic [C-1:0]   sch_en  [MAXC];
  logic [W-1:0]   sch_d   [MAXC][C];
  logic           sch_rdy [MAXC];
  logic           sch_clr [MAXC];
  logic           sch_rst [MAXC];
  // Row descriptions, indexed by the cycle of the column-0 strobe.
  logic [C-1:0]   row_mask [MAXC];
  logic [C*W-1:0] row_val  [MAXC];
  logic           kill     [MAXC];

  logic [C*W-1:0] exp_q[$];
  logic           e_ovf = 1'b0;
  logic           e_skw = 1'b0;

  task automatic check(input string name, input logic [C*W-1:0] act, input logic [C*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [W-1:0] w);
`ifdef PE_COL_DRAIN_RELU_EN
    return ($signed(w) < 0) ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic issue_row(input int s, input logic [C-1:0] mask, input logic [W-1:0] w [C]);
    row_mask[s] = mask;
    for (int j = 0; j < C; j++) begin
      row_val[s][j*W +: W] = model_word(w[j]);
      sch_en[s+j][j] = mask[j];
      if (mask[j]) sch_d[s+j][j] = w[j];
    end
  endtask

  task automatic rand_row(input int s, input logic [C-1:0] mask);
    logic [W-1:0] w [C];
    for (int j = 0; j < C; j++) w[j] = $urandom;
    issue_row(s, mask, w);
  endtask

  task automatic build_schedule();
    logic [W-1:0] w [C];
    for (int c = 0; c < MAXC; c++) begin
      sch_en[c] = '0; sch_rdy[c] = 1'b1; sch_clr[c] = 1'b0; sch_rst[c] = 1'b0;
      row_mask[c] = '0; row_val[c] = '0; kill[c] = 1'b0;
      for (int j = 0; j < C; j++) sch_d[c][j] = $urandom;
    end
    // Single row, ready high.
    w = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC};
    issue_row(10, '1, w);
    // Fill to full with ready low, then a fifth row overflows; drain from cycle 45.
    for (int c = 21; c < 45; c++) sch_rdy[c] = 1'b0;
    for (int s = 30; s < 35; s++) rand_row(s, '1);
    // Flush, refill, then a push coinciding with a pop while full.
    sch_clr[55] = 1'b1;
    for (int c = 56; c < 80; c++) sch_rdy[c] = (c == 73);
    for (int s = 60; s < 64; s++) rand_row(s, '1);
    rand_row(70, '1);
    // One good row held, then a row missing column 2, then a flush.
    for (int c = 90; c < 140; c++) sch_rdy[c] = 1'b0;
    rand_row(95, '1);
    rand_row(100, 4'b1011);
    sch_clr[110] = 1'b1;
    // Asynchronous reset pulse after columns 0 and 1 of a row have strobed.
    rand_row(120, '1);
    rand_row(130, '1);
    sch_rst[132] = 1'b1;
    // Mixed-sign row for the clamp option.
    w = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_8000};
    issue_row(150, '1, w);
    // Random traffic.
    for (int s = 200; s < 1200; s++) begin
      if ($urandom_range(0, 99) < 45)
        rand_row(s, ($urandom_range(0, 9) == 0) ? C'($urandom_range(1, (1 << C) - 2)) : '1);
      sch_rdy[s] = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 199) == 0) sch_clr[s] = 1'b1;
    end
  endtask

  // Driver: inputs change 1 time unit after each rising edge.
  initial begin
    build_schedule();
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_count", count, '0);
    check("rst_data", data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_skew_err", skew_err, 1'b0);
    while (cyc < END_CYC) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 2) rst = 1'b0;
      en_up = sch_en[cyc];
      for (int j = 0; j < C; j++)
        data_up[j*W +: W] = sch_en[cyc][j] ? sch_d[cyc][j] : W'($urandom);
      ready = sch_rdy[cyc];
      clr   = sch_clr[cyc];
      if (sch_rst[cyc]) begin
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", valid, 1'b0);
        check("async_rst_count", count, '0);
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor and reference model: compare on the falling edge, then advance the model
  // by the events of the rising edge that ends this cycle.
  initial begin
    int s;
    int sz0;
    logic pop;
    logic [C-1:0] m;
    forever begin
      @(negedge clk);
      if (cyc >= 3 && cyc < MAXC) begin
        if (sch_rst[cyc]) begin
          exp_q.delete();
          e_ovf = 1'b0;
          e_skw = 1'b0;
          for (int k = cyc - C + 1; k < cyc; k++) if (k >= 0) kill[k] = 1'b1;
        end
        check("valid", valid, exp_q.size() != 0);
        check("count", count, exp_q.size());
        check("overflow", overflow, e_ovf);
        check("skew_err", skew_err, e_skw);
        if (exp_q.size() != 0) check("data", data, exp_q[0]);

        if (sch_clr[cyc]) begin
          exp_q.delete();
          e_ovf = 1'b0;
          e_skw = 1'b0;
          for (int k = cyc - C + 1; k <= cyc; k++) if (k >= 0) kill[k] = 1'b1;
        end else begin
          s   = cyc - C + 1;
          sz0 = exp_q.size();
          pop = (sz0 != 0) && sch_rdy[cyc];
          m   = (s >= 0 && !kill[s]) ? row_mask[s] : '0;
          if (m != '0 && m != '1) e_skw = 1'b1;
          if (pop) void'(exp_q.pop_front());
          if (m == '1) begin
            if (sz0 == D && !pop) e_ovf = 1'b1;
            else exp_q.push_back(row_val[s]);
          end
        end
      end
    end
  end

endmodule
